// File: rtl/flit_buffer_pkg.sv
// flit_buffer_pkg: shared widths and flit field offsets for the flit buffer
package flit_buffer_pkg;
  function automatic int flit_w(input int v, input int fpay);
    return 2 + v + fpay;
  endfunction
  function automatic int bv_w(input int v, input int b);
    return v * b;
  endfunction
  function automatic int ptr_w(input int b);
    return $clog2(b);
  endfunction
  function automatic int payload_lsb();
    return 0;
  endfunction
  function automatic int vc_lsb(input int fpay);
    return fpay;
  endfunction
  function automatic int tail_bit(input int v, input int fpay);
    return fpay + v;
  endfunction
  function automatic int hdr_bit(input int v, input int fpay);
    return fpay + v + 1;
  endfunction
endpackage

// File: rtl/flit_buffer_ram.sv
// fb_sdp_ram: simple dual-port flit RAM with a registered, resettable read port
module fb_sdp_ram #(
  parameter int DEPTH = 8,
  parameter int W = 36,
  parameter int AW = 3
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  din,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem [DEPTH];
  // storage is never cleared; a same-address read returns the old word
  always_ff @(posedge clk)
    if (we) mem[waddr] <= din;
  // read register only updates on a valid pop, so dout holds otherwise
  always_ff @(posedge clk)
    if (reset) dout <= '0;
    else if (re) dout <= mem[raddr];
endmodule

// File: rtl/flit_buffer.sv
// flit_buffer: per-VC flit FIFOs sharing one RAM, with optional SSA pops
module flit_buffer
  import flit_buffer_pkg::*;
#(
  parameter int V = 2,
  parameter int B = 4,
  parameter int Fpay = 32,
  parameter string SSA_EN = "NO",
  localparam int FW = flit_w(V, Fpay),
  localparam int BV = bv_w(V, B),
  localparam int PTRW = ptr_w(B)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic [FW-1:0] din,
  input  logic [V-1:0]  vc_num_wr,
  input  logic          wr_en,
  input  logic [V-1:0]  vc_num_rd,
  input  logic          rd_en,
  input  logic [V-1:0]  ssa_rd,
  output logic [FW-1:0] dout,
  output logic [V-1:0]  vc_not_empty
);
  localparam bit SSA = (SSA_EN == "YES");
  localparam int VW = V > 1 ? $clog2(V) : 1;
  localparam int AW = VW + PTRW;
  logic [V-1:0] rd_vec, pop, wr_ok;
  logic [V-1:0][PTRW-1:0] wr_ptr, rd_ptr;
  logic [VW-1:0] wr_vc, rd_vc;
  assign rd_vec = (rd_en ? vc_num_rd : '0) | (SSA ? ssa_rd : '0);
  // one-hot VC selects to binary indices for RAM addressing
  always_comb begin
    wr_vc = '0;
    rd_vc = '0;
    for (int i = 0; i < V; i++) begin
      wr_vc = wr_vc | (vc_num_wr[i] ? VW'(i) : '0);
      rd_vc = rd_vc | (rd_vec[i] ? VW'(i) : '0);
    end
  end
  for (genvar i = 0; i < V; i++) begin : g_vc
    logic [PTRW-1:0] wp, rp;
    logic [PTRW:0] depth;
    assign pop[i] = rd_vec[i] && depth != '0;
    assign wr_ok[i] = wr_en && vc_num_wr[i] && (depth != (PTRW+1)'(B) || pop[i]);
    assign wr_ptr[i] = wp;
    assign rd_ptr[i] = rp;
    assign vc_not_empty[i] = depth != '0;
    // per-VC pointers wrap modulo B; depth tracks accepted writes minus pops
    always_ff @(posedge clk)
      if (reset) begin
        wp <= '0;
        rp <= '0;
        depth <= '0;
      end else begin
        if (wr_ok[i]) wp <= wp + PTRW'(1);
        if (pop[i]) rp <= rp + PTRW'(1);
        depth <= depth + (PTRW+1)'(wr_ok[i]) - (PTRW+1)'(pop[i]);
      end
  end
  fb_sdp_ram #(.DEPTH(BV), .W(FW), .AW(AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (|wr_ok),
    .waddr ({wr_vc, wr_ptr[wr_vc]}),
    .din   (din),
    .re    (|pop),
    .raddr ({rd_vc, rd_ptr[rd_vc]}),
    .dout  (dout)
  );
  a_wr_onehot: assert property (@(posedge clk) disable iff (reset) wr_en |-> $onehot0(vc_num_wr));
  a_rd_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rd_vec));
endmodule

// File: tb/tb_flit_buffer.sv
// tb_flit_buffer: directed self-checking bench for flit_buffer (SSA on and off)
module tb_flit_buffer;
  logic clk = 0, reset;
  logic [35:0] din, dout_y, dout_n;
  logic [1:0] vc_num_wr, vc_num_rd, ssa_rd, ne_y, ne_n;
  logic wr_en, rd_en;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  flit_buffer #(.V(2), .B(4), .Fpay(32), .SSA_EN("YES")) dut_y (
    .clk(clk), .reset(reset), .din(din), .vc_num_wr(vc_num_wr), .wr_en(wr_en),
    .vc_num_rd(vc_num_rd), .rd_en(rd_en), .ssa_rd(ssa_rd), .dout(dout_y), .vc_not_empty(ne_y)
  );
  flit_buffer #(.V(2), .B(4), .Fpay(32), .SSA_EN("NO")) dut_n (
    .clk(clk), .reset(reset), .din(din), .vc_num_wr(vc_num_wr), .wr_en(wr_en),
    .vc_num_rd(vc_num_rd), .rd_en(rd_en), .ssa_rd(ssa_rd), .dout(dout_n), .vc_not_empty(ne_n)
  );
  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int vc, input logic [35:0] d);
    vc_num_wr = 2'b01 << vc;
    din = d;
    wr_en = 1;
    step();
    wr_en = 0;
    vc_num_wr = 0;
  endtask
  task automatic pop(input int vc);
    vc_num_rd = 2'b01 << vc;
    rd_en = 1;
    step();
    rd_en = 0;
    vc_num_rd = 0;
  endtask
  task automatic wr_pop(input int vc, input logic [35:0] d);
    vc_num_wr = 2'b01 << vc;
    vc_num_rd = 2'b01 << vc;
    din = d;
    wr_en = 1;
    rd_en = 1;
    step();
    wr_en = 0;
    rd_en = 0;
    vc_num_wr = 0;
    vc_num_rd = 0;
  endtask
  initial begin
    din = 0; vc_num_wr = 0; vc_num_rd = 0; ssa_rd = 0; wr_en = 0; rd_en = 0; reset = 1;
    step(); step();
    reset = 0;
    step();
    chk("rst_ne", 36'(ne_y), 36'h0);
    chk("rst_dout", dout_y, 36'h0);
    for (int i = 0; i < 4; i++) wr(0, 36'hA0 + 36'(i));
    chk("fifo_ne_full", 36'(ne_y), 36'h1);
    for (int i = 0; i < 4; i++) begin
      pop(0);
      chk("fifo_dout", dout_y, 36'hA0 + 36'(i));
      chk("fifo_ne", 36'(ne_y), i == 3 ? 36'h0 : 36'h1);
    end
    for (int i = 0; i < 4; i++) wr(1, 36'hD0 + 36'(i));
    wr(1, 36'hFF);
    chk("full_ne", 36'(ne_y), 36'h2);
    for (int i = 0; i < 4; i++) begin
      pop(1);
      chk("full_dout", dout_y, 36'hD0 + 36'(i));
    end
    chk("full_ne_empty", 36'(ne_y), 36'h0);
    pop(1);
    chk("empty_pop_hold", dout_y, 36'hD3);
    for (int r = 0; r < 3; r++) begin
      wr(0, 36'hB0 + 36'(r << 8));
      wr(1, 36'hC0 + 36'(r << 8));
      wr(0, 36'hB1 + 36'(r << 8));
      wr(1, 36'hC1 + 36'(r << 8));
      chk("il_ne", 36'(ne_y), 36'h3);
      pop(1); chk("il_c0", dout_y, 36'hC0 + 36'(r << 8));
      pop(0); chk("il_b0", dout_y, 36'hB0 + 36'(r << 8));
      pop(1); chk("il_c1", dout_y, 36'hC1 + 36'(r << 8));
      pop(0); chk("il_b1", dout_y, 36'hB1 + 36'(r << 8));
      chk("il_ne_end", 36'(ne_y), 36'h0);
    end
    wr(0, 36'hE0);
    wr(0, 36'hE1);
    wr_pop(0, 36'hE2);
    chk("wp2_dout", dout_y, 36'hE0);
    pop(0); chk("wp2_e1", dout_y, 36'hE1); chk("wp2_ne", 36'(ne_y), 36'h1);
    pop(0); chk("wp2_e2", dout_y, 36'hE2); chk("wp2_ne_end", 36'(ne_y), 36'h0);
    wr_pop(1, 36'hF1);
    chk("wpe_hold", dout_y, 36'hE2);
    chk("wpe_ne", 36'(ne_y), 36'h2);
    pop(1); chk("wpe_f1", dout_y, 36'hF1); chk("wpe_ne_end", 36'(ne_y), 36'h0);
    for (int i = 0; i < 4; i++) wr(0, 36'h10 + 36'(i));
    wr_pop(0, 36'h14);
    chk("wpf_dout", dout_y, 36'h10);
    for (int i = 1; i < 5; i++) begin
      pop(0);
      chk("wpf_pop", dout_y, 36'h10 + 36'(i));
    end
    chk("wpf_ne_end", 36'(ne_y), 36'h0);
    wr(0, 36'h55);
    ssa_rd = 2'b01;
    step();
    ssa_rd = 0;
    chk("ssa_yes_dout", dout_y, 36'h55);
    chk("ssa_yes_ne", 36'(ne_y), 36'h0);
    chk("ssa_no_dout", dout_n, 36'h14);
    chk("ssa_no_ne", 36'(ne_n), 36'h1);
    pop(0);
    chk("ssa_no_pop", dout_n, 36'h55);
    chk("ssa_no_ne_end", 36'(ne_n), 36'h0);
    chk("ssa_yes_hold", dout_y, 36'h55);
    wr(0, 36'h77);
    vc_num_wr = 2'b10; din = 36'h88; wr_en = 1; reset = 1;
    step();
    wr_en = 0; vc_num_wr = 0; reset = 0;
    chk("mid_rst_ne", 36'(ne_y), 36'h0);
    chk("mid_rst_dout", dout_y, 36'h0);
    pop(1);
    chk("mid_rst_pop", dout_y, 36'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
